// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the board reset sequencer.
// Sequencer states plus the index-width helper used to size the domain pointer.
package rst_seq_pkg;

  // The original encoding is 2 bits wide; FAULT uses the third bit.
  typedef enum logic [2:0] {
    HOLD    = 3'b000,
    WAIT    = 3'b001,
    STAGGER = 3'b010,
    DONE    = 3'b011,
    FAULT   = 3'b100
  } seq_state_t;

  localparam int FAULT_DOM_W = 3;

  function automatic int clog2_dom(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reset_sequencer_synch.sv
// Two-stage reset synchronizer on the falling clock edge.
// Assertion is asynchronous; release is clean before the next rising edge.
module reset_synch (
  input  logic clk,
  input  logic RST_n,
  output logic rst_n
);

  logic meta_q;
  logic rst_n_q;

  always_ff @(negedge clk or negedge RST_n) begin
    if (!RST_n) begin
      meta_q  <= 1'b0;
      rst_n_q <= 1'b0;
    end else begin
      meta_q  <= 1'b1;
      rst_n_q <= meta_q;
    end
  end

  assign rst_n = rst_n_q;

endmodule

// File: rtl/reset_sequencer.sv
// Releases N_DOM reset domains in order, waiting for each ready with a stagger,
// and flags a timeout fault; soft_rst_req restarts the whole sequence.
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int N_DOM       = 4,
  parameter int HOLD_CYC    = 16,
  parameter int STAGGER_CYC = 50000,
  parameter int TMO_CYC     = 1000000,
  parameter int CNT_W       = 20
) (
  input  logic             clk,
  input  logic             RST_n,
  input  logic             soft_rst_req,
  input  logic [N_DOM-1:0] dom_rdy,
  output logic [N_DOM-1:0] rst_n_out,
  output logic             seq_done,
  output logic             seq_fault,
  output logic [2:0]       fault_dom
);

  localparam int IW = clog2_dom(N_DOM);
  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;
  localparam bit PARAMS_OK = (N_DOM >= 2) && (N_DOM <= 8) &&
                             (HOLD_CYC >= 1) && (STAGGER_CYC >= 1) && (TMO_CYC >= 1) &&
                             (HOLD_CYC <= CNT_MAX) && (STAGGER_CYC <= CNT_MAX) &&
                             (TMO_CYC <= CNT_MAX);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] STG_LAST  = CNT_W'(STAGGER_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TMO_CYC - 1);
  localparam logic [IW-1:0]    LAST_IDX  = IW'(N_DOM - 1);

  logic rst_n_int;

  reset_synch u_synch (
    .clk   (clk),
    .RST_n (RST_n),
    .rst_n (rst_n_int)
  );

  seq_state_t                 state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]              idx_q, idx_d, idx_inc;
  logic [N_DOM-1:0]           rst_n_out_q, rst_n_out_d;
  logic                       seq_done_q, seq_done_d;
  logic                       seq_fault_q, seq_fault_d;
  logic [FAULT_DOM_W-1:0]     fault_dom_q, fault_dom_d;

  assign idx_inc = idx_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    rst_n_out_d = rst_n_out_q;
    seq_done_d  = seq_done_q;
    seq_fault_d = seq_fault_q;
    fault_dom_d = fault_dom_q;
    if (soft_rst_req) begin
      state_d     = HOLD;
      cnt_d       = '0;
      idx_d       = '0;
      rst_n_out_d = '0;
      seq_done_d  = 1'b0;
      seq_fault_d = 1'b0;
      fault_dom_d = '0;
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d     = WAIT;
            cnt_d       = '0;
            idx_d       = '0;
            rst_n_out_d = N_DOM'(1);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        WAIT: begin
          cnt_d = cnt_q + 1'b1;
          // Ready beats a coincident timeout.
          if (dom_rdy[idx_q]) begin
            if (idx_q == LAST_IDX) begin
              state_d    = DONE;
              seq_done_d = 1'b1;
            end else begin
              state_d = STAGGER;
              cnt_d   = '0;
            end
          end else if (cnt_q == TMO_LAST) begin
            state_d     = FAULT;
            seq_fault_d = 1'b1;
            fault_dom_d = FAULT_DOM_W'(idx_q);
          end
        end
        STAGGER: begin
          if (cnt_q == STG_LAST) begin
            state_d     = WAIT;
            cnt_d       = '0;
            idx_d       = idx_inc;
            rst_n_out_d = rst_n_out_q | (N_DOM'(1) << idx_inc);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DONE, FAULT: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q     <= HOLD;
      cnt_q       <= '0;
      idx_q       <= '0;
      rst_n_out_q <= '0;
      seq_done_q  <= 1'b0;
      seq_fault_q <= 1'b0;
      fault_dom_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      rst_n_out_q <= rst_n_out_d;
      seq_done_q  <= seq_done_d;
      seq_fault_q <= seq_fault_d;
      fault_dom_q <= fault_dom_d;
    end
  end

  assign rst_n_out = rst_n_out_q;
  assign seq_done  = seq_done_q;
  assign seq_fault = seq_fault_q;
  assign fault_dom = fault_dom_q;

  param_legal_a: assert property (@(posedge clk) PARAMS_OK)
    else $error("reset_sequencer: illegal parameter set");

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Board-level reset controller for the quadcopter driver. It synchronizes the raw push-button/POR reset and releases N downstream reset domains in a fixed order, e.g. 0=SPI/IMU, 1=A2D, 2=flight ctrl, 3=ESC PWM. Each domain must report ready before the next is released, with a fixed stagger between releases. It also provides a soft-reset request, a timeout fault and a sequence-done flag for the command/config logic.

Parameters:
N_DOM, 4, number of sequenced reset domains (2..8)
HOLD_CYC, 16, clocks all domains stay in reset after the internal reset releases or a soft reset
STAGGER_CYC, 50000, clocks between domain i reporting ready and domain i+1 being released (1 ms at 50 MHz)
TMO_CYC, 1000000, max clocks to wait for dom_rdy[i] after releasing domain i (20 ms)
CNT_W, 20, counter width; must hold max(HOLD_CYC, STAGGER_CYC, TMO_CYC)

Ports:
clk  in  1  system clock
RST_n  in  1  raw reset, asynchronous, active-low
soft_rst_req  in  1  synchronous pulse requesting a full re-sequence
dom_rdy  in  N_DOM  per-domain ready; synchronous to clk
rst_n_out  out  N_DOM  per-domain reset, active-low, registered
seq_done  out  1  all domains released and ready
seq_fault  out  1  a domain failed to report ready within TMO_CYC
fault_dom  out  3  index of the failing domain; valid while seq_fault=1

Behaviour:
- Reset input: RST_n is asynchronous, active-low.
- Internal synchronization:
  - RST_n feeds a 2-flop synchronizer clocked on negedge clk, producing rst_n_int.
  - Assertion of rst_n_int is asynchronous; deassertion takes 2 negedges.
  - All FSM and counter flops are on posedge clk and reset asynchronously by rst_n_int.
- Reset values: rst_n_out=0 (all bits), seq_done=0, seq_fault=0, fault_dom=0, state=HOLD, cnt=0, idx=0.
- HOLD state:
  - All rst_n_out=0 and cnt increments each clock.
  - When cnt==HOLD_CYC-1, go to WAIT with idx=0 and cnt cleared.
  - rst_n_out[0] goes to 1 on that same edge.
- WAIT(idx) state:
  - rst_n_out[idx:0]=1 and all higher bits are 0. cnt increments each clock.
  - If dom_rdy[idx]=1:
    - idx==N_DOM-1: go to DONE; seq_done=1 on that edge.
    - otherwise: go to STAGGER with cnt cleared.
  - Else if cnt==TMO_CYC-1: go to FAULT.
  - If ready and timeout occur in the same cycle, ready wins.
- STAGGER state:
  - cnt increments. When cnt==STAGGER_CYC-1, go to WAIT(idx+1) with cnt cleared.
  - rst_n_out[idx+1] rises on that edge.
  - dom_rdy is ignored in this state.
- DONE state:
  - Holds all rst_n_out=1 and seq_done=1.
  - Later deassertion of dom_rdy is ignored; software issues soft_rst_req to recover.
- FAULT state:
  - seq_fault=1 and fault_dom=idx.
  - Domains 0..idx keep their current rst_n_out values; domains idx+1..N_DOM-1 stay 0.
  - The block stays here until soft_rst_req or RST_n.
- soft_rst_req:
  - Sampled in every state, including HOLD, where it restarts the count.
  - Next edge: all rst_n_out=0, seq_done=0, seq_fault=0, fault_dom=0, cnt=0, idx=0, state=HOLD.
  - It has priority over every other transition in the same cycle.
- RST_n mid-sequence: all outputs return to reset values immediately, with no clock needed.
- Latency (no soft reset, dom_rdy already high):
  - rst_n_out[0] rises HOLD_CYC posedges after rst_n_int deasserts.
  - Each later domain k rises 1+STAGGER_CYC clocks after domain k-1: 1 WAIT cycle, then STAGGER.
  - seq_done rises 1 clock after rst_n_out[N_DOM-1].
- Width rules:
  - Counter comparisons use CNT_W bits; parameter values above 2^CNT_W-1 are illegal (assert in simulation).
  - fault_dom is zero-extended idx.

Decomposition:
- Package rst_seq_pkg holds:
  - typedef enum logic [1:0] {HOLD, WAIT, STAGGER, DONE} seq_state_t
  - FAULT as a separate 3rd-bit encoding; seq_state_t is widened to 3 bits to include it
  - function clog2_dom for idx width
- Sub-module: the existing reset_synch is instantiated unchanged for the RST_n to rst_n_int path.
- The FSM, counter and output registers stay in reset_sequencer.

Test Plan:
Bench parameters: N_DOM=3, HOLD_CYC=4, STAGGER_CYC=8, TMO_CYC=20.
- Power-up, dom_rdy=3'b111: release RST_n -> rst_n_out 000 for 2 negedges + 4 clocks; then 001, 011 (9 clocks later), 111 (9 clocks later); seq_done=1 one clock after 111; seq_fault=0 throughout.
- Domain 1 slow: dom_rdy[1] rises 12 clocks after rst_n_out[1] -> rst_n_out[2] rises 12+8 clocks after rst_n_out[1]; no fault.
- Timeout: dom_rdy[1] held 0 -> exactly 20 clocks after rst_n_out[1] rises, seq_fault=1, fault_dom=1, rst_n_out=011 held; a later dom_rdy[1] has no effect.
- Race: dom_rdy[1] rises in cycle cnt==19 -> no fault, STAGGER entered.
- soft_rst_req in DONE and again in FAULT -> next edge rst_n_out=000, seq_done=0, seq_fault=0; full sequence replays with identical timing. soft_rst_req in HOLD -> 4-clock count restarts.
- RST_n pulsed low mid-STAGGER, not aligned to any clock -> rst_n_out=000 and seq_done=0 immediately (no clock needed); clean re-sequence after release.
